// File: rtl/cp0_irq_timer.sv
// MIPS coprocessor 0 for the multi-cycle core: Status/Cause/EPC, Count/Compare
// timer and level-sensitive external interrupts with exception redirect.
module cp0_irq_timer #(
    parameter int unsigned NUM_IRQ    = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h4,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mfc0,
    input  logic               mtc0,
    input  logic [4:0]         rd,
    input  logic [31:0]        wdata,
    input  logic [31:0]        pc,
    input  logic               exception,
    input  logic [4:0]         cause,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        rdata,
    output logic [31:0]        status,
    output logic [31:0]        epc,
    output logic               timer_int,
    output logic               exc_take,
    output logic [31:0]        exc_addr
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [31:0]   status_q, status_d;
    logic [31:0]   epc_q, epc_d;
    logic [4:0]    exc_code_q, exc_code_d;
    logic [6:0]    ip_ext_q, ip_ext_d;
    logic          ip_timer_q, ip_timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          take_q, take_d;
    logic [31:0]   addr_q, addr_d;

    logic [7:0]    ip;
    logic          int_req;
    logic          do_mtc0;
    logic          wr_count;
    logic          wr_compare;
    logic          tick;
    logic [31:0]   count_inc;

    // rdata is combinational and always valid, so the read strobe carries no work
    logic unused;
    assign unused = mfc0;

    assign ip         = {ip_timer_q, ip_ext_q};
    assign int_req    = status_q[0] & ~status_q[1] & (|(ip & status_q[15:8]));
    assign do_mtc0    = mtc0 & ~exception & ~int_req & ~eret;
    assign wr_count   = do_mtc0 && (rd == REG_COUNT);
    assign wr_compare = do_mtc0 && (rd == REG_COMPARE);
    assign tick       = (presc_q == PW'(COUNT_DIV - 1));
    assign count_inc  = 32'(count_q + 32'd1);

    // Exception / interrupt / eret / mtc0 arbitration, one action per cycle
    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        exc_code_d = exc_code_q;
        take_d     = 1'b0;
        addr_d     = addr_q;
        if (exception) begin
            take_d = 1'b1;
            if (!status_q[1]) begin
                status_d[1] = 1'b1;
                exc_code_d  = cause;
                epc_d       = pc;
                addr_d      = EXC_VECTOR;
            end else begin
                addr_d = pc;
            end
        end else if (int_req) begin
            take_d      = 1'b1;
            status_d[1] = 1'b1;
            exc_code_d  = 5'd0;
            epc_d       = pc;
            addr_d      = EXC_VECTOR;
        end else if (eret) begin
            take_d      = 1'b1;
            status_d[1] = 1'b0;
            addr_d      = epc_q;
        end else if (mtc0) begin
            case (rd)
                REG_STATUS: status_d = wdata;
                REG_EPC:    epc_d    = wdata;
                default:    ;
            endcase
        end
    end

    // Count/Compare timer; a software write wins over the same-cycle tick
    always_comb begin
        count_d    = count_q;
        compare_d  = compare_q;
        presc_d    = presc_q;
        ip_timer_d = ip_timer_q;
        ip_ext_d   = 7'(irq);
        if (wr_count) begin
            count_d = wdata;
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
            count_d = count_inc;
            if (count_inc == compare_q) begin
                ip_timer_d = 1'b1;
            end
        end else begin
            presc_d = PW'(presc_q + 1'b1);
        end
        if (wr_compare) begin
            compare_d  = wdata;
            ip_timer_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            exc_code_q <= '0;
            ip_ext_q   <= '0;
            ip_timer_q <= 1'b0;
            presc_q    <= '0;
            take_q     <= 1'b0;
            addr_q     <= '0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            exc_code_q <= exc_code_d;
            ip_ext_q   <= ip_ext_d;
            ip_timer_q <= ip_timer_d;
            presc_q    <= presc_d;
            take_q     <= take_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        case (rd)
            REG_COUNT:   rdata = count_q;
            REG_COMPARE: rdata = compare_q;
            REG_STATUS:  rdata = status_q;
            REG_CAUSE:   rdata = {16'h0, ip, 1'b0, exc_code_q, 2'b00};
            REG_EPC:     rdata = epc_q;
            default:     rdata = 32'h0;
        endcase
    end

    assign status    = status_q;
    assign epc       = epc_q;
    assign timer_int = ip_timer_q;
    assign exc_take  = take_q;
    assign exc_addr  = addr_q;

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Self-checking bench for cp0_irq_timer: directed scenarios plus random traffic
// against a cycle-level reference model, checked through a scoreboard.
module tb_cp0_irq_timer;

    localparam int unsigned NUM_IRQ    = 6;
    localparam logic [31:0] EXC_VECTOR = 32'h4;
    localparam int unsigned COUNT_DIV  = 2;
    localparam logic [31:0] STATUS_RST = 32'h1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mfc0 = 1'b0;
    logic               mtc0 = 1'b0;
    logic [4:0]         rd = 5'd0;
    logic [31:0]        wdata = 32'h0;
    logic [31:0]        pc = 32'h0;
    logic               exception = 1'b0;
    logic [4:0]         cause = 5'd0;
    logic               eret = 1'b0;
    logic [NUM_IRQ-1:0] irq = '0;
    logic [31:0]        rdata;
    logic [31:0]        status;
    logic [31:0]        epc;
    logic               timer_int;
    logic               exc_take;
    logic [31:0]        exc_addr;

    cp0_irq_timer #(
        .NUM_IRQ(NUM_IRQ), .EXC_VECTOR(EXC_VECTOR),
        .COUNT_DIV(COUNT_DIV), .STATUS_RST(STATUS_RST)
    ) dut (
        .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .rd(rd), .wdata(wdata),
        .pc(pc), .exception(exception), .cause(cause), .eret(eret), .irq(irq),
        .rdata(rdata), .status(status), .epc(epc), .timer_int(timer_int),
        .exc_take(exc_take), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    typedef struct {
        logic        take;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] ep;
        logic        tint;
    } exp_t;

    exp_t        state_q[$];
    logic [31:0] take_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: architectural state; Count = base + elapsed_ticks / COUNT_DIV
    logic [31:0] m_status, m_compare, m_epc, m_base, m_addr;
    int unsigned m_ticks;
    logic        m_ip7;
    logic [6:0]  m_ext;
    logic [4:0]  m_exc;
    logic [NUM_IRQ-1:0] cur_irq = '0;

    function automatic logic [31:0] m_count();
        return 32'(m_base + 32'(m_ticks / COUNT_DIV));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        case (r)
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return {16'h0, m_ip7, m_ext, 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = STATUS_RST; m_compare = 0; m_epc = 0; m_base = 0; m_addr = 0;
        m_ticks = 0; m_ip7 = 0; m_ext = 0; m_exc = 0;
    endtask

    // One clock of stimulus: drive at negedge, check read port, advance model, wait
    task automatic step(input logic ex, input logic [4:0] cs, input logic er,
                        input logic mt, input logic [4:0] r, input logic [31:0] wd,
                        input logic [31:0] p, input logic [NUM_IRQ-1:0] iq);
        logic [7:0]  ipv;
        logic        ireq, take, ld_cnt, wr_cmp;
        logic [31:0] old_cmp;
        exception = ex; cause = cs; eret = er; mtc0 = mt; mfc0 = ~mt;
        rd = r; wdata = wd; pc = p; irq = iq;
        #1;
        check($sformatf("rdata_rd%0d", r), rdata, m_read(r));
        ipv = {m_ip7, m_ext};
        ireq = m_status[0] & ~m_status[1] & (|(ipv & m_status[15:8]));
        take = 0; ld_cnt = 0; wr_cmp = 0; old_cmp = m_compare;
        if (ex) begin
            take = 1;
            if (!m_status[1]) begin
                m_status[1] = 1; m_exc = cs; m_epc = p; m_addr = EXC_VECTOR;
            end else begin
                m_addr = p;
            end
        end else if (ireq) begin
            take = 1; m_status[1] = 1; m_exc = 0; m_epc = p; m_addr = EXC_VECTOR;
        end else if (er) begin
            take = 1; m_status[1] = 0; m_addr = m_epc;
        end else if (mt) begin
            case (r)
                5'd9:  begin m_base = wd; m_ticks = 0; ld_cnt = 1; end
                5'd11: wr_cmp = 1;
                5'd12: m_status = wd;
                5'd14: m_epc = wd;
                default: ;
            endcase
        end
        if (!ld_cnt) begin
            m_ticks++;
            if ((m_ticks % COUNT_DIV) == 0 && m_count() == old_cmp) m_ip7 = 1;
        end
        if (wr_cmp) begin m_compare = wd; m_ip7 = 0; end
        m_ext = 7'(iq);
        if (take) take_q.push_back(m_addr);
        state_q.push_back('{take, m_addr, m_status, m_epc, m_ip7});
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] p);
        step(0, 0, 0, 0, 5'($urandom_range(8, 15)), 0, p, cur_irq);
    endtask
    task automatic wr(input logic [4:0] r, input logic [31:0] wd);
        step(0, 0, 0, 1, r, wd, 32'h40, cur_irq);
    endtask
    task automatic do_eret();
        step(0, 0, 1, 0, 5'd14, 0, 32'h44, cur_irq);
    endtask
    task automatic rd_check(input string name, input logic [4:0] r, input logic [31:0] exp);
        mtc0 = 0; rd = r;
        #1;
        check(name, rdata, exp);
    endtask

    // Scoreboard monitor: every non-reset edge has one state record; takes pop redirects
    always @(posedge clk) begin : mon
        exp_t        e;
        logic [31:0] a;
        #1;
        if (!rst) begin
            if (exc_take) begin
                check("take_expected", 32'(take_q.size() != 0), 32'd1);
                if (take_q.size() != 0) begin
                    a = take_q.pop_front();
                    check("take_addr", exc_addr, a);
                end
            end
            check("state_expected", 32'(state_q.size() != 0), 32'd1);
            if (state_q.size() != 0) begin
                e = state_q.pop_front();
                check("exc_take", 32'(exc_take), 32'(e.take));
                check("exc_addr", exc_addr, e.addr);
                check("status", status, e.st);
                check("epc", epc, e.ep);
                check("timer_int", 32'(timer_int), 32'(e.tint));
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_status", status, STATUS_RST);
        check("reset_take", 32'(exc_take), 0);
        check("reset_epc", epc, 0);
        check("reset_addr", exc_addr, 0);
        rst = 0;

        // Timer interrupt from Compare match
        wr(9, 0); wr(11, 5); wr(12, 32'h8001);
        repeat (8) idle(0);
        check("t1_timer_int", 32'(timer_int), 1);
        check("t1_no_take_yet", 32'(exc_take), 0);
        idle(32'h100);
        check("t1_take", 32'(exc_take), 1);
        check("t1_addr", exc_addr, 32'h4);
        check("t1_epc", epc, 32'h100);
        wr(11, 32'h1000);
        check("t1_compare_clears", 32'(timer_int), 0);
        do_eret();
        check("t1_eret_addr", exc_addr, 32'h100);

        // Masked irq, then unmasked
        wr(12, 32'h0001);
        cur_irq = 6'b000100;
        repeat (3) idle(0);
        check("t2_masked", 32'(exc_take), 0);
        wr(12, 32'h0401);
        check("t2_not_yet", 32'(exc_take), 0);
        idle(32'h200);
        check("t2_take", 32'(exc_take), 1);
        rd_check("t2_cause", 13, 32'h0000_0400);
        cur_irq = 0;
        idle(0);
        do_eret();
        check("t2_eret_addr", exc_addr, 32'h200);

        // Exception beats pending irq; irq taken after eret
        wr(12, 32'h0201);
        cur_irq = 6'b000010;
        idle(0);
        step(1, 5'd8, 0, 0, 5'd0, 0, 32'h300, cur_irq);
        check("t3_take", 32'(exc_take), 1);
        check("t3_addr", exc_addr, 32'h4);
        check("t3_epc", epc, 32'h300);
        idle(0);
        check("t3_one_pulse", 32'(exc_take), 0);
        rd_check("t3_cause", 13, 32'h0000_0220);
        do_eret();
        check("t3_eret_addr", exc_addr, 32'h300);
        idle(32'h400);
        check("t3_irq_take", 32'(exc_take), 1);
        check("t3_irq_epc", epc, 32'h400);
        rd_check("t3_irq_cause", 13, 32'h0000_0200);

        // Nested exception while EXL=1
        step(1, 5'd4, 0, 0, 5'd0, 0, 32'h500, cur_irq);
        check("t4_take", 32'(exc_take), 1);
        check("t4_addr", exc_addr, 32'h500);
        check("t4_epc", epc, 32'h400);
        check("t4_exl", 32'(status[1]), 1);

        // Asynchronous reset mid-operation
        rst = 1; irq = '0; cur_irq = '0;
        #1;
        check("t6_status", status, STATUS_RST);
        check("t6_take", 32'(exc_take), 0);
        rd_check("t6_count", 9, 0);
        @(negedge clk);
        state_q.delete(); take_q.delete(); model_reset();
        rst = 0;

        // Count wrap hits Compare=0
        wr(12, 32'h0001); wr(11, 0); wr(9, 32'hFFFF_FFFF);
        idle(0); idle(0);
        check("t5_timer_int", 32'(timer_int), 1);
        rd_check("t5_count", 9, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        ex, er, mt;
            logic [4:0]  r;
            logic [31:0] wd;
            int unsigned sel;
            ex = ($urandom_range(0, 99) < 4);
            er = ($urandom_range(0, 99) < 8);
            mt = ($urandom_range(0, 99) < 25);
            r  = 5'($urandom_range(0, 31));
            wd = $urandom;
            if (mt) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1: begin
                        r = 9;
                        wd = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                         : 32'($urandom_range(0, 20));
                    end
                    2, 3: begin r = 11; wd = 32'(m_count() + $urandom_range(0, 8)); end
                    4, 5, 6: begin
                        r = 12;
                        wd = {16'h0, 8'($urandom), 6'h0,
                              ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0)};
                    end
                    7: r = 14;
                    default: ;
                endcase
            end
            if ($urandom_range(0, 9) == 0) cur_irq = NUM_IRQ'($urandom);
            step(ex, 5'($urandom), er, mt, r, wd, $urandom & 32'hFFFF_FFFC, cur_irq);
        end

        check("take_queue_drained", 32'(take_q.size()), 0);
        check("state_queue_drained", 32'(state_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
